// File: rtl/fir_tap_sequencer.sv
// FIR tap sequencer: writes each accepted sample into the circular buffer, sweeps the taps
// newest-to-oldest driving the MAC, waits out the MAC latency, then holds the result valid.
module fir_tap_sequencer #(
   parameter int unsigned AWIDTH  = 6,
   parameter int unsigned NTAPS   = 56,
   parameter int unsigned MAC_LAT = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              smp_vld,
   input  logic              out_rdy,
   input  logic              ovr_clr,
   output logic              mem_we,
   output logic [AWIDTH-1:0] mem_waddr,
   output logic [AWIDTH-1:0] mem_raddr,
   output logic [AWIDTH-1:0] coef_addr,
   output logic              mac_en,
   output logic              mac_clr,
   output logic              mac_last,
   output logic              acc_vld,
   output logic              busy,
   output logic              overrun,
   output logic              primed
);

   localparam int unsigned CW = $clog2(NTAPS + 1);
   localparam int unsigned DW = $clog2(MAC_LAT + 2);
   localparam logic [AWIDTH-1:0] LastTap   = AWIDTH'(NTAPS - 1);
   localparam logic [DW-1:0]     LastDrain = DW'((MAC_LAT == 0) ? 0 : MAC_LAT - 1);
   localparam logic [CW-1:0]     PrimeCnt  = CW'(NTAPS);

   typedef enum logic [2:0] {StIdle, StWrite, StRun, StDrain, StOut} state_e;

   state_e            state_q, state_d;
   logic [AWIDTH-1:0] wp_q, wp_d;
   logic [DW-1:0]     drain_q, drain_d;
   logic [CW-1:0]     smp_cnt_q, smp_cnt_d;
   logic [AWIDTH-1:0] waddr_d, raddr_d, coef_d;
   logic              we_d, en_d, clr_d, last_d, vld_d, busy_d, ovr_d, primed_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (smp_vld) state_d = StWrite;
         StWrite: state_d = StRun;
         StRun:   if (coef_addr == LastTap) state_d = (MAC_LAT == 0) ? StOut : StDrain;
         StDrain: if (drain_q == LastDrain) state_d = StOut;
         StOut:   if (out_rdy) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Outputs are computed from the next state so every port comes straight from a flop.
   always_comb begin
      wp_d      = wp_q;
      coef_d    = coef_addr;
      raddr_d   = mem_raddr;
      waddr_d   = mem_waddr;
      drain_d   = '0;
      smp_cnt_d = smp_cnt_q;
      if (state_q == StWrite) begin
         wp_d    = wp_q + AWIDTH'(1);
         coef_d  = '0;
         raddr_d = wp_q;
      end else if (state_q == StRun && state_d == StRun) begin
         coef_d  = coef_addr + AWIDTH'(1);
         raddr_d = mem_raddr - AWIDTH'(1);
      end
      if (state_q == StDrain) drain_d = drain_q + DW'(1);
      if (state_d == StWrite) begin
         waddr_d = wp_q;
         if (smp_cnt_q != PrimeCnt) smp_cnt_d = smp_cnt_q + CW'(1);
      end
      we_d     = (state_d == StWrite);
      en_d     = (state_d == StRun);
      clr_d    = (state_d == StRun) && (coef_d == '0);
      last_d   = (state_d == StRun) && (coef_d == LastTap);
      vld_d    = (state_d == StOut);
      busy_d   = (state_d != StIdle);
      primed_d = (smp_cnt_d == PrimeCnt);
      // A drop outranks a simultaneous clear.
      if (smp_vld && state_q != StIdle) ovr_d = 1'b1;
      else if (ovr_clr)                 ovr_d = 1'b0;
      else                              ovr_d = overrun;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp_q      <= '0;
         drain_q   <= '0;
         smp_cnt_q <= '0;
         mem_we    <= 1'b0;
         mem_waddr <= '0;
         mem_raddr <= '0;
         coef_addr <= '0;
         mac_en    <= 1'b0;
         mac_clr   <= 1'b0;
         mac_last  <= 1'b0;
         acc_vld   <= 1'b0;
         busy      <= 1'b0;
         overrun   <= 1'b0;
         primed    <= 1'b0;
      end else begin
         wp_q      <= wp_d;
         drain_q   <= drain_d;
         smp_cnt_q <= smp_cnt_d;
         mem_we    <= we_d;
         mem_waddr <= waddr_d;
         mem_raddr <= raddr_d;
         coef_addr <= coef_d;
         mac_en    <= en_d;
         mac_clr   <= clr_d;
         mac_last  <= last_d;
         acc_vld   <= vld_d;
         busy      <= busy_d;
         overrun   <= ovr_d;
         primed    <= primed_d;
      end
   end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer: default build plus a NTAPS=1, MAC_LAT=0 build.
module tb_fir_tap_sequencer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic smp_vld = 1'b0, out_rdy = 1'b1, ovr_clr = 1'b0;
   logic mem_we, mac_en, mac_clr, mac_last, acc_vld, busy, overrun, primed;
   logic [5:0] mem_waddr, mem_raddr, coef_addr;
   logic smp2 = 1'b0, rdy2 = 1'b1, clr2 = 1'b0;
   logic we2, en2, mclr2, last2, vld2, busy2, ovr2, primed2;
   logic [5:0] waddr2, raddr2, coef2;

   int chk_cnt = 0;
   int pass_cnt = 0;

   always #5 clk = ~clk;

   fir_tap_sequencer dut (
      .clk(clk), .rst_n(rst_n), .smp_vld(smp_vld), .out_rdy(out_rdy), .ovr_clr(ovr_clr),
      .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_raddr(mem_raddr), .coef_addr(coef_addr),
      .mac_en(mac_en), .mac_clr(mac_clr), .mac_last(mac_last), .acc_vld(acc_vld),
      .busy(busy), .overrun(overrun), .primed(primed)
   );

   fir_tap_sequencer #(.AWIDTH(6), .NTAPS(1), .MAC_LAT(0)) dut_small (
      .clk(clk), .rst_n(rst_n), .smp_vld(smp2), .out_rdy(rdy2), .ovr_clr(clr2),
      .mem_we(we2), .mem_waddr(waddr2), .mem_raddr(raddr2), .coef_addr(coef2),
      .mac_en(en2), .mac_clr(mclr2), .mac_last(last2), .acc_vld(vld2),
      .busy(busy2), .overrun(ovr2), .primed(primed2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      #3;
      rst_n = 1'b1;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 200) begin
         tick();
         n++;
      end
      chk_cnt++;
      if (busy !== 1'b0) $display("FAIL %s idle timeout: busy=%b required 0", name, busy);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      logic [25:0] got;
      #2;
      got = {mem_we, mem_waddr, mem_raddr, coef_addr, mac_en, mac_clr, mac_last, acc_vld,
             busy, overrun, primed};
      chk_cnt++;
      if (got !== 26'd0) $display("FAIL reset_outputs: got %h required 0", got);
      else pass_cnt++;
      rst_n = 1'b1;
      tick();
      chk_cnt++;
      if (busy !== 1'b0) $display("FAIL reset_idle: busy=%b required 0", busy);
      else pass_cnt++;
   endtask

   task automatic test_single();
      logic [5:0] exp_r;
      smp_vld = 1'b1;
      tick();
      smp_vld = 1'b0;
      chk_cnt++;
      if ({mem_we, mem_waddr, busy} !== {1'b1, 6'd0, 1'b1})
         $display("FAIL single_write: we=%b waddr=%0d busy=%b required 1/0/1",
                  mem_we, mem_waddr, busy);
      else pass_cnt++;
      for (int k = 0; k < 56; k++) begin
         tick();
         exp_r = 6'(64 - k);
         chk_cnt++;
         if ({mem_raddr, coef_addr, mac_en, mac_clr, mac_last, mem_we} !==
             {exp_r, 6'(k), 1'b1, (k == 0), (k == 55), 1'b0})
            $display("FAIL single_tap%0d: raddr=%0d coef=%0d en/clr/last=%b%b%b required %0d %0d",
                     k, mem_raddr, coef_addr, mac_en, mac_clr, mac_last, exp_r, k);
         else pass_cnt++;
      end
      for (int d = 0; d < 3; d++) begin
         tick();
         chk_cnt++;
         if ({mac_en, mac_clr, mac_last, acc_vld} !== 4'b0000)
            $display("FAIL single_drain%0d: en/clr/last/vld=%b%b%b%b required 0000",
                     d, mac_en, mac_clr, mac_last, acc_vld);
         else pass_cnt++;
      end
      tick();
      chk_cnt++;
      if (acc_vld !== 1'b1) $display("FAIL single_vld_e60: acc_vld=%b required 1", acc_vld);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if ({acc_vld, busy} !== 2'b00)
         $display("FAIL single_idle_e61: vld=%b busy=%b required 0 0", acc_vld, busy);
      else pass_cnt++;
   endtask

   task automatic test_wrap();
      apply_reset();
      for (int i = 0; i < 70; i++) begin
         smp_vld = 1'b1;
         tick();
         smp_vld = 1'b0;
         chk_cnt++;
         if ({mem_we, mem_waddr, primed} !== {1'b1, 6'(i), (i >= 55)})
            $display("FAIL wrap_write%0d: we=%b waddr=%0d primed=%b required 1 %0d %b",
                     i, mem_we, mem_waddr, primed, i % 64, (i >= 55));
         else pass_cnt++;
         for (int c = 1; c < 64; c++) begin
            tick();
            if (c == 1) begin
               chk_cnt++;
               if (mem_raddr !== 6'(i))
                  $display("FAIL wrap_tap0_%0d: raddr=%0d required %0d", i, mem_raddr, i % 64);
               else pass_cnt++;
            end
            if (c == 56) begin
               chk_cnt++;
               if ({mem_raddr, mac_last} !== {6'(i + 64 - 55), 1'b1})
                  $display("FAIL wrap_tap55_%0d: raddr=%0d last=%b required %0d 1",
                           i, mem_raddr, mac_last, (i + 9) % 64);
               else pass_cnt++;
            end
         end
      end
      chk_cnt++;
      if (overrun !== 1'b0) $display("FAIL wrap_overrun: overrun=%b required 0", overrun);
      else pass_cnt++;
   endtask

   task automatic test_overrun();
      apply_reset();
      smp_vld = 1'b1;
      tick();
      smp_vld = 1'b0;
      for (int c = 1; c < 30; c++) tick();
      smp_vld = 1'b1;
      tick();
      smp_vld = 1'b0;
      chk_cnt++;
      if ({mem_we, mem_waddr, overrun, coef_addr} !== {1'b0, 6'd0, 1'b1, 6'd29})
         $display("FAIL ovr_drop: we=%b waddr=%0d ovr=%b coef=%0d required 0 0 1 29",
                  mem_we, mem_waddr, overrun, coef_addr);
      else pass_cnt++;
      ovr_clr = 1'b1;
      tick();
      chk_cnt++;
      if (overrun !== 1'b0) $display("FAIL ovr_clear: overrun=%b required 0", overrun);
      else pass_cnt++;
      smp_vld = 1'b1;
      tick();
      smp_vld = 1'b0;
      ovr_clr = 1'b0;
      chk_cnt++;
      if (overrun !== 1'b1) $display("FAIL ovr_set_wins: overrun=%b required 1", overrun);
      else pass_cnt++;
      wait_idle("ovr");
      chk_cnt++;
      if (overrun !== 1'b1) $display("FAIL ovr_sticky: overrun=%b required 1", overrun);
      else pass_cnt++;
      ovr_clr = 1'b1;
      tick();
      ovr_clr = 1'b0;
      chk_cnt++;
      if (overrun !== 1'b0) $display("FAIL ovr_idle_clear: overrun=%b required 0", overrun);
      else pass_cnt++;
   endtask

   task automatic test_out_hold();
      int held = 0;
      apply_reset();
      out_rdy = 1'b0;
      smp_vld = 1'b1;
      tick();
      smp_vld = 1'b0;
      for (int c = 1; c <= 60; c++) tick();
      for (int c = 0; c < 20; c++) begin
         if (acc_vld === 1'b1) held++;
         smp_vld = (c == 10);
         tick();
         smp_vld = 1'b0;
         if (c == 10) begin
            chk_cnt++;
            if ({mem_we, overrun} !== 2'b01)
               $display("FAIL hold_drop: we=%b ovr=%b required 0 1", mem_we, overrun);
            else pass_cnt++;
         end
      end
      chk_cnt++;
      if (held != 20 || acc_vld !== 1'b1)
         $display("FAIL hold_vld: held=%0d vld=%b required 20 1", held, acc_vld);
      else pass_cnt++;
      out_rdy = 1'b1;
      tick();
      chk_cnt++;
      if ({acc_vld, busy} !== 2'b00)
         $display("FAIL hold_release: vld=%b busy=%b required 0 0", acc_vld, busy);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      logic [25:0] got;
      apply_reset();
      for (int i = 0; i < 2; i++) begin
         smp_vld = 1'b1;
         tick();
         smp_vld = 1'b0;
         wait_idle("mid_pre");
      end
      smp_vld = 1'b1;
      tick();
      smp_vld = 1'b0;
      for (int c = 1; c <= 21; c++) tick();
      chk_cnt++;
      if ({coef_addr, mem_raddr} !== {6'd20, 6'd46})
         $display("FAIL mid_tap20: coef=%0d raddr=%0d required 20 46", coef_addr, mem_raddr);
      else pass_cnt++;
      rst_n = 1'b0;
      #1;
      got = {mem_we, mem_waddr, mem_raddr, coef_addr, mac_en, mac_clr, mac_last, acc_vld,
             busy, overrun, primed};
      chk_cnt++;
      if (got !== 26'd0) $display("FAIL mid_reset_outputs: got %h required 0", got);
      else pass_cnt++;
      rst_n = 1'b1;
      tick();
      chk_cnt++;
      if (acc_vld !== 1'b0) $display("FAIL mid_no_vld: vld=%b required 0", acc_vld);
      else pass_cnt++;
      smp_vld = 1'b1;
      tick();
      smp_vld = 1'b0;
      chk_cnt++;
      if ({mem_we, mem_waddr, primed} !== {1'b1, 6'd0, 1'b0})
         $display("FAIL mid_restart: we=%b waddr=%0d primed=%b required 1 0 0",
                  mem_we, mem_waddr, primed);
      else pass_cnt++;
      wait_idle("mid_post");
   endtask

   task automatic test_small();
      apply_reset();
      for (int i = 0; i < 6; i++) begin
         smp2 = 1'b1;
         tick();
         smp2 = 1'b0;
         chk_cnt++;
         if ({we2, waddr2, primed2} !== {1'b1, 6'(i), 1'b1})
            $display("FAIL small_write%0d: we=%b waddr=%0d primed=%b required 1 %0d 1",
                     i, we2, waddr2, primed2, i);
         else pass_cnt++;
         tick();
         chk_cnt++;
         if ({en2, mclr2, last2, raddr2, coef2} !== {3'b111, 6'(i), 6'd0})
            $display("FAIL small_tap%0d: en/clr/last=%b%b%b raddr=%0d coef=%0d required 111 %0d 0",
                     i, en2, mclr2, last2, raddr2, coef2, i);
         else pass_cnt++;
         tick();
         chk_cnt++;
         if ({vld2, en2} !== 2'b10)
            $display("FAIL small_vld%0d: vld=%b en=%b required 1 0", i, vld2, en2);
         else pass_cnt++;
         tick();
         chk_cnt++;
         if ({vld2, busy2} !== 2'b00)
            $display("FAIL small_idle%0d: vld=%b busy=%b required 0 0", i, vld2, busy2);
         else pass_cnt++;
      end
      chk_cnt++;
      if (ovr2 !== 1'b0) $display("FAIL small_overrun: overrun=%b required 0", ovr2);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_wrap();
      test_overrun();
      test_out_hold();
      test_reset_mid();
      test_small();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
